// File: rtl/encrypt_round.sv
// encrypt_round -- iterative AES-128 encryption, one round per clock.
//
// A 128-bit cipher key is loaded with set_key. start (sampled in IDLE) encrypts
// one plaintext block. Round keys are derived on the fly from the previous
// round key, so no key schedule is stored. The ciphertext appears on `out`
// 10 cycles after the accept edge, together with a one-cycle out_valid pulse.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           level request to encrypt `state` (sampled in IDLE)
//   set_key         load `key` into the key register (IDLE only)
//   halt            synchronous abort (only with ENCRYPT_ROUND_HALT_EN)
//   state, key      plaintext / cipher key, byte 0 = bits [127:120], column-major
//   out             ciphertext, holds the last result
//   out_valid       one-cycle pulse when `out` carries a new ciphertext
//
// Build option:
//   ENCRYPT_ROUND_HALT_EN  when defined, halt returns the engine to IDLE and
//                          drops the block in flight; when undefined, halt is
//                          ignored and every accepted block completes.

module encrypt_round (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         set_key,
    input  logic         halt,
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic [127:0] out,
    output logic         out_valid
);

    typedef enum logic {IDLE, RUN} fsm_t;

    // S-box, entry x at bits [8*(255-x) +: 8] (entry 0 is the most significant byte).
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        // 255 - x == ~x, so the table offset is simply {~x, 3'b000}
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
        return r;
    endfunction

    // byte b lives at bits [127-8b -: 8]; byte (row r, col c) is b = r + 4c
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                r[127 - 8*(rw + 4*c) -: 8] = s[127 - 8*(rw + 4*((c + rw) % 4)) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            // 3*a == xtime(a) ^ a
            r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] rot, t, n0, n1, n2, n3;
        rot = {k[23:0], k[31:24]};
        t   = {sbox(rot[31:24]) ^ rc, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        n0  = k[127:96] ^ t;
        n1  = k[95:64]  ^ n0;
        n2  = k[63:32]  ^ n1;
        n3  = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    fsm_t         fsm;
    logic [127:0] key_reg, data_reg, rkey_reg;
    logic [3:0]   round;

    logic         halt_req;
`ifdef ENCRYPT_ROUND_HALT_EN
    assign halt_req = halt;
`else
    logic unused_halt;
    assign unused_halt = halt;
    assign halt_req    = 1'b0;
`endif

    logic [127:0] k0, sr, mc, ki;
    // a key presented together with start is used for that very block
    assign k0 = set_key ? key : key_reg;
    assign sr = shift_rows(sub_bytes(data_reg));
    assign mc = mix_columns(sr);
    assign ki = key_expand(rkey_reg, rcon(round));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            key_reg   <= '0;
            data_reg  <= '0;
            rkey_reg  <= '0;
            round     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (halt_req) begin
                fsm   <= IDLE;
                round <= '0;
            end else begin
                case (fsm)
                    IDLE: begin
                        if (set_key) key_reg <= key;
                        if (start) begin
                            data_reg <= state ^ k0;
                            rkey_reg <= k0;
                            round    <= 4'd1;
                            fsm      <= RUN;
                        end
                    end
                    RUN: begin
                        if (round == 4'd10) begin
                            // final round skips MixColumns
                            out       <= sr ^ ki;
                            out_valid <= 1'b1;
                            round     <= '0;
                            fsm       <= IDLE;
                        end else begin
                            data_reg <= mc ^ ki;
                            rkey_reg <= ki;
                            round    <= round + 4'd1;
                        end
                    end
                    default: fsm <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_encrypt_round.sv
// Scoreboard bench for encrypt_round: stimulus pushes the expected ciphertext
// and the cycle it must appear on; a monitor pops on every out_valid pulse.
module tb_encrypt_round;

    logic         clk = 1'b0;
    logic         rst_n, start, set_key, halt;
    logic [127:0] state, key, out;
    logic         out_valid;

    encrypt_round dut (
        .clk(clk), .rst_n(rst_n), .start(start), .set_key(set_key), .halt(halt),
        .state(state), .key(key), .out(out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    typedef struct {
        logic [127:0] ct;
        int           due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // drive a start request; it is accepted on the next edge and the result
    // must be visible 11 edges after the current one
    task automatic issue(input logic [127:0] pt, input logic [127:0] k,
                         input logic sk, input logic expect_out, input logic [127:0] ct);
        exp_t e;
        state = pt; key = k; set_key = sk; start = 1'b1;
        if (expect_out) begin
            e.ct = ct; e.due = cyc + 11;
            q.push_back(e);
        end
        tick(1);
        start = 1'b0; set_key = 1'b0;
    endtask

    // monitor
    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {127'b0, out_valid}, 128'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ciphertext", out, e.ct);
                chk("pulse_cycle", 128'(cyc), 128'(e.due));
            end
        end
    end

    initial begin
        int n;
        exp_t e;
        rst_n = 1'b0; start = 1'b0; set_key = 1'b0; halt = 1'b0;
        state = '0; key = '0;

        // reset state
        tick(2);
        chk("reset_out", out, '0);
        chk("reset_valid", {127'b0, out_valid}, '0);
        rst_n = 1'b1;
        tick(3);
        chk("idle_out", out, '0);
        chk("idle_valid", {127'b0, out_valid}, '0);

        // FIPS-197 B: key loaded first, then start
        key = KEY_B; set_key = 1'b1;
        tick(1);
        set_key = 1'b0;
        issue(PT_B, '0, 1'b0, 1'b1, CT_B);
        tick(14);

        // start held high: two blocks 11 cycles apart
        n = cyc;
        state = PT_B; start = 1'b1;
        e.ct = CT_B; e.due = n + 11; q.push_back(e);
        e.ct = CT_B; e.due = n + 22; q.push_back(e);
        tick(12);
        start = 1'b0;
        tick(14);

        // FIPS-197 C.1: set_key and start together
        issue(PT_C1, KEY_C1, 1'b1, 1'b1, CT_C1);
        tick(14);

        // halt during round 5 of a B block (key loaded with the start)
        n = cyc;
`ifdef ENCRYPT_ROUND_HALT_EN
        issue(PT_B, KEY_B, 1'b1, 1'b0, '0);
`else
        issue(PT_B, KEY_B, 1'b1, 1'b1, CT_B);
`endif
        tick(4);
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        tick(n + 12 - cyc);
`ifdef ENCRYPT_ROUND_HALT_EN
        chk("halt_retains_out", out, CT_C1);
`else
        chk("halt_ignored_out", out, CT_B);
`endif
        tick(3);
        // key register holds KEY_B after the halted/ignored block
        issue(PT_B, '0, 1'b0, 1'b1, CT_B);
        tick(14);

        // reset in the middle of a run
        issue(PT_C1, KEY_C1, 1'b1, 1'b0, '0);
        tick(4);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_out", out, '0);
        chk("midrun_reset_valid", {127'b0, out_valid}, '0);
        tick(2);
        rst_n = 1'b1;
        tick(15);
        chk("post_reset_out", out, '0);
        chk("post_reset_valid", {127'b0, out_valid}, '0);

        chk("pending_results", 128'(q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
